// File: rtl/warp_issue_scheduler.sv
// Four-warp round-robin issue scheduler: filters warps with thread hazards, issues over valid/ready, and drives the scoreboard busy-set port.
// Optional feature macro WARP_AGE_EN: per-warp saturating age counters that override round-robin for starved warps.
module warp_issue_scheduler #(
  parameter int unsigned NUM_WARPS        = 4,
  parameter int unsigned THREADS_PER_WARP = 8,
  parameter int unsigned NUM_THREADS      = NUM_WARPS * THREADS_PER_WARP
`ifdef WARP_AGE_EN
  ,
  parameter int unsigned AGE_LIMIT        = 12
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WARPS-1:0]     warp_valid,
  input  logic [NUM_WARPS-1:0]     warp_is_mem,
  input  logic [4*NUM_WARPS-1:0]   warp_threads_mask,
  input  logic [NUM_THREADS-1:0]   warp_active_threads,
  input  logic [NUM_THREADS-1:0]   busy_threads,
  input  logic                     issue_ready,
  output logic                     issue_valid,
  output logic [1:0]               issue_warp,
  output logic [3:0]               issue_threads_mask,
  output logic                     issue_is_mem,
  output logic [NUM_WARPS-1:0]     warp_pop,
  output logic                     busy_en,
  output logic [1:0]               warp_num_busy,
  output logic [3:0]               threads_mask_busy
);

  localparam int unsigned WID_W  = 2;
  localparam int unsigned MASK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WID_W-1:0]   r_rr_ptr;
  logic [NUM_WARPS-1:0] w_eligible;
  logic               w_any_eligible;
  logic               w_rr_found;
  logic [WID_W-1:0]   w_rr_warp;
  logic               w_pick_found;
  logic [WID_W-1:0]   w_pick_warp;
  logic               w_load;
  logic               w_fire;

  // A warp is eligible when none of its instruction's lanes are marked busy.
  always_comb begin : eligibility
    w_eligible = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      w_eligible[w] = warp_valid[w] &&
        ((warp_active_threads[w*THREADS_PER_WARP +: THREADS_PER_WARP] &
          busy_threads[w*THREADS_PER_WARP +: THREADS_PER_WARP]) == '0);
    end
  end

  assign w_any_eligible = |w_eligible;

  // First eligible warp scanning upward from the round-robin pointer.
  always_comb begin : rr_pick
    w_rr_found = 1'b0;
    w_rr_warp  = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      if (!w_rr_found && w_eligible[r_rr_ptr + WID_W'(i)]) begin
        w_rr_found = 1'b1;
        w_rr_warp  = r_rr_ptr + WID_W'(i);
      end
    end
  end

`ifdef WARP_AGE_EN
  localparam int unsigned AGE_W = 4;

  logic [NUM_WARPS-1:0][AGE_W-1:0] r_age;
  logic                            w_old_found;
  logic [WID_W-1:0]                w_old_warp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_age <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        if (warp_pop[w]) begin
          r_age[w] <= '0;
        end else if (warp_valid[w] && (r_age[w] != '1)) begin
          r_age[w] <= r_age[w] + AGE_W'(1);
        end
      end
    end
  end

  // Lowest-id starved warp wins over the round-robin choice.
  always_comb begin : age_pick
    w_old_found = 1'b0;
    w_old_warp  = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      if (!w_old_found && w_eligible[w] && (r_age[w] >= AGE_W'(AGE_LIMIT))) begin
        w_old_found = 1'b1;
        w_old_warp  = WID_W'(w);
      end
    end
  end

  assign w_pick_found = w_old_found | w_rr_found;
  assign w_pick_warp  = w_old_found ? w_old_warp : w_rr_warp;
`else
  assign w_pick_found = w_rr_found;
  assign w_pick_warp  = w_rr_warp;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin : fsm_next
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_eligible) begin
          w_state_nxt = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (w_pick_found) begin
          w_load      = 1'b1;
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (issue_valid && issue_ready) begin
          w_fire      = 1'b1;
          w_state_nxt = ST_SELECT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Held instruction and round-robin pointer; the pointer advances past the warp just accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid        <= 1'b0;
      issue_warp         <= '0;
      issue_threads_mask <= '0;
      issue_is_mem       <= 1'b0;
      r_rr_ptr           <= '0;
    end else if (w_load) begin
      issue_valid        <= 1'b1;
      issue_warp         <= w_pick_warp;
      issue_threads_mask <= warp_threads_mask[w_pick_warp*MASK_W +: MASK_W];
      issue_is_mem       <= warp_is_mem[w_pick_warp];
    end else if (w_fire) begin
      issue_valid        <= 1'b0;
      r_rr_ptr           <= issue_warp + WID_W'(1);
    end
  end

  // Handshake-cycle strobes; busy-set only for memory instructions.
  assign warp_pop          = w_fire ? (NUM_WARPS'(1) << issue_warp) : '0;
  assign busy_en           = w_fire & issue_is_mem;
  assign warp_num_busy     = busy_en ? issue_warp : '0;
  assign threads_mask_busy = busy_en ? issue_threads_mask : '0;

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Self-checking bench for warp_issue_scheduler: directed scenarios plus randomized traffic against a transaction-level model.
module tb_warp_issue_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  warp_valid;
  logic [3:0]  warp_is_mem;
  logic [15:0] warp_threads_mask;
  logic [31:0] warp_active_threads;
  logic [31:0] busy_threads;
  logic        issue_ready;
  logic        issue_valid;
  logic [1:0]  issue_warp;
  logic [3:0]  issue_threads_mask;
  logic        issue_is_mem;
  logic [3:0]  warp_pop;
  logic        busy_en;
  logic [1:0]  warp_num_busy;
  logic [3:0]  threads_mask_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] b_v;
  logic [3:0] b_mem;
  logic [3:0] b_mask  [4];
  logic [7:0] b_lanes [4];
  logic [7:0] b_busy  [4];

  warp_issue_scheduler dut (
    .clk                 (clk),
    .reset               (reset),
    .warp_valid          (warp_valid),
    .warp_is_mem         (warp_is_mem),
    .warp_threads_mask   (warp_threads_mask),
    .warp_active_threads (warp_active_threads),
    .busy_threads        (busy_threads),
    .issue_ready         (issue_ready),
    .issue_valid         (issue_valid),
    .issue_warp          (issue_warp),
    .issue_threads_mask  (issue_threads_mask),
    .issue_is_mem        (issue_is_mem),
    .warp_pop            (warp_pop),
    .busy_en             (busy_en),
    .warp_num_busy       (warp_num_busy),
    .threads_mask_busy   (threads_mask_busy)
  );

  always #5 clk = ~clk;

  task automatic apply_inputs();
    warp_valid  = b_v;
    warp_is_mem = b_mem;
    for (int w = 0; w < 4; w++) begin
      warp_threads_mask[w*4 +: 4]   = b_mask[w];
      warp_active_threads[w*8 +: 8] = b_lanes[w];
      busy_threads[w*8 +: 8]        = b_busy[w];
    end
  endtask

  task automatic setup_warps(input logic [3:0] v, input logic [3:0] mem);
    b_v   = v;
    b_mem = mem;
    for (int w = 0; w < 4; w++) begin
      b_mask[w]  = 4'(w + 1);
      b_lanes[w] = 8'hFF;
      b_busy[w]  = 8'h00;
    end
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    setup_warps(4'hF, 4'h0);
    issue_ready = 1'b1;
    apply_inputs();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({issue_valid, issue_warp, issue_threads_mask, issue_is_mem} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_issue: got %h required 00",
               {issue_valid, issue_warp, issue_threads_mask, issue_is_mem});
    end
    n_cmp++;
    if ({warp_pop, busy_en, warp_num_busy, threads_mask_busy} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_hs: got %h required 000",
               {warp_pop, busy_en, warp_num_busy, threads_mask_busy});
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cycle1_valid: got %b required 0", issue_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({issue_valid, issue_warp} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_first_issue: got valid=%b warp=%0d required valid=1 warp=0",
               issue_valid, issue_warp);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_o[5] = '{0, 1, 2, 3, 0};
    int last_c = -1;
    setup_warps(4'hF, 4'h0);
    issue_ready = 1'b1;
    apply_inputs();
    do_reset();
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      @(posedge clk); #1;
      if (warp_pop != 4'h0) begin
        n_cmp++;
        if ($countones(warp_pop) != 1) begin
          n_fail++;
          $display("FAIL rr_onehot: got pop=%b required one-hot", warp_pop);
        end
        n_cmp++;
        if (busy_en !== 1'b0) begin
          n_fail++;
          $display("FAIL rr_busy_en: got %b required 0", busy_en);
        end
        n_cmp++;
        if (issue_threads_mask !== b_mask[issue_warp]) begin
          n_fail++;
          $display("FAIL rr_mask: got %h required %h", issue_threads_mask, b_mask[issue_warp]);
        end
        if (last_c >= 0) begin
          n_cmp++;
          if (c - last_c != 2) begin
            n_fail++;
            $display("FAIL rr_gap: got %0d cycles required 2", c - last_c);
          end
        end
        last_c = c;
        for (int w = 0; w < 4; w++) if (warp_pop[w]) order.push_back(w);
      end
    end
    n_cmp++;
    if (order.size() != 5) begin
      n_fail++;
      $display("FAIL rr_count: got %0d issues required 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (order[i] != exp_o[i]) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: got warp %0d required %0d", i, order[i], exp_o[i]);
        end
      end
    end
  endtask

  task automatic test_mem_busy();
    bit found = 0;
    int w1_pops = 0;
    int other_pops = 0;
    setup_warps(4'hF, 4'b0010);
    b_mask[1] = 4'hF;
    issue_ready = 1'b1;
    apply_inputs();
    do_reset();
    for (int c = 0; c < 30 && !found; c++) begin
      @(posedge clk); #1;
      if (warp_pop[1]) begin
        found = 1;
        n_cmp++;
        if ({busy_en, warp_num_busy, threads_mask_busy} !== 7'b1_01_1111) begin
          n_fail++;
          $display("FAIL mem_busy_set: got en=%b num=%0d mask=%h required en=1 num=1 mask=f",
                   busy_en, warp_num_busy, threads_mask_busy);
        end
      end else if (warp_pop != 4'h0) begin
        n_cmp++;
        if (busy_en !== 1'b0) begin
          n_fail++;
          $display("FAIL mem_nonmem_busy: got %b required 0", busy_en);
        end
      end
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL mem_timeout: got no warp1 issue required one within 30 cycles");
    end
    @(posedge clk); #1;
    b_busy[1] = 8'hFF;
    apply_inputs();
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (warp_pop[1]) w1_pops++;
      else if (warp_pop != 4'h0) other_pops++;
    end
    n_cmp++;
    if (w1_pops != 0) begin
      n_fail++;
      $display("FAIL mem_skip: got %0d warp1 issues while busy required 0", w1_pops);
    end
    n_cmp++;
    if (other_pops < 6) begin
      n_fail++;
      $display("FAIL mem_others: got %0d other issues required >=6", other_pops);
    end
    b_busy[1] = 8'h00;
    apply_inputs();
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk); #1;
      if (warp_pop[1]) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL mem_resume: got no warp1 issue after clear required one within 20 cycles");
    end
  endtask

  task automatic test_stall();
    bit seen = 0;
    setup_warps(4'b0100, 4'h0);
    b_mask[2] = 4'h5;
    issue_ready = 1'b0;
    apply_inputs();
    do_reset();
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      if (issue_valid) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL stall_timeout: got no issue_valid required within 10 cycles");
    end
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({issue_valid, issue_warp, issue_threads_mask, issue_is_mem, warp_pop} !== 12'b1_10_0101_0_0000) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b w=%0d m=%h mem=%b pop=%b required v=1 w=2 m=5 mem=0 pop=0000",
                 c, issue_valid, issue_warp, issue_threads_mask, issue_is_mem, warp_pop);
      end
      @(posedge clk); #1;
    end
    issue_ready = 1'b1;
    #1;
    n_cmp++;
    if (warp_pop !== 4'b0100) begin
      n_fail++;
      $display("FAIL stall_pop: got %b required 0100", warp_pop);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got valid=%b required 0", issue_valid);
    end
    // Reset while holding drops the instruction without a pop.
    issue_ready = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      if (issue_valid) seen = 1;
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({issue_valid, warp_pop} !== 5'b0) begin
      n_fail++;
      $display("FAIL stall_reset_drop: got v=%b pop=%b required v=0 pop=0000", issue_valid, warp_pop);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({issue_valid, issue_warp} !== 3'b110) begin
      n_fail++;
      $display("FAIL stall_represent: got v=%b w=%0d required v=1 w=2", issue_valid, issue_warp);
    end
  endtask

  task automatic test_idle_wake();
    setup_warps(4'b1000, 4'h0);
    b_lanes[3] = 8'h0F;
    b_busy[3]  = 8'h03;
    issue_ready = 1'b1;
    apply_inputs();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (issue_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_blocked[%0d]: got valid=%b required 0", c, issue_valid);
      end
    end
    b_busy[3] = 8'h00;
    apply_inputs();
    @(posedge clk); #1;
    n_cmp++;
    if (issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_select_cycle: got valid=%b required 0", issue_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({issue_valid, issue_warp} !== 3'b111) begin
      n_fail++;
      $display("FAIL idle_wake_issue: got v=%b w=%0d required v=1 w=3", issue_valid, issue_warp);
    end
  endtask

`ifdef WARP_AGE_EN
  task automatic test_age();
    bit found = 0;
    setup_warps(4'hF, 4'h0);
    b_lanes[0] = 8'h01;
    b_busy[0]  = 8'h01;
    issue_ready = 1'b1;
    apply_inputs();
    do_reset();
    repeat (16) @(posedge clk);
    #1;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk); #1;
      if (warp_pop[1]) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL age_setup_timeout: got no warp1 issue required one within 20 cycles");
    end
    b_busy[0] = 8'h00;
    apply_inputs();
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(posedge clk); #1;
      if (warp_pop != 4'h0) begin
        found = 1;
        n_cmp++;
        if (warp_pop !== 4'b0001) begin
          n_fail++;
          $display("FAIL age_override: got pop=%b required 0001", warp_pop);
        end
      end
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL age_timeout: got no issue required one within 10 cycles");
    end
  endtask
`endif

  task automatic new_instr(input int w);
    b_v[w]     = ($urandom % 3) != 0;
    b_mem[w]   = 1'($urandom);
    b_mask[w]  = 4'($urandom);
    b_lanes[w] = 8'(1 << ($urandom % 8)) | (8'($urandom) & 8'($urandom));
  endtask

  // Transaction-level model: one held slot, a pick opportunity after each accept or wake-up.
  task automatic test_random();
    bit         m_held = 0;
    bit         m_pick_turn = 0;
    logic [1:0] m_rr = 2'd0;
    logic [1:0] m_warp = 2'd0;
    logic [3:0] m_mask = 4'h0;
    logic       m_mem = 1'b0;
    logic [7:0] m_lanes = 8'h00;
    int         m_age[4] = '{0, 0, 0, 0};
    bit         elig[4];
    bit         fire;
    bit         found;
    int         pw;
    logic [3:0] e_pop;
    logic       e_ben;
    logic [1:0] e_num;
    logic [3:0] e_tm;
    for (int w = 0; w < 4; w++) begin
      new_instr(w);
      b_busy[w] = 8'h00;
    end
    issue_ready = 1'b1;
    apply_inputs();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      issue_ready = ($urandom % 4) != 0;
      apply_inputs();
      #1;
      for (int w = 0; w < 4; w++) elig[w] = b_v[w] && ((b_lanes[w] & b_busy[w]) == 8'h00);
      fire  = m_held && issue_ready;
      e_pop = fire ? (4'b0001 << m_warp) : 4'h0;
      e_ben = fire && m_mem;
      e_num = e_ben ? m_warp : 2'd0;
      e_tm  = e_ben ? m_mask : 4'h0;
      n_cmp++;
      if ({issue_valid, warp_pop, busy_en, warp_num_busy, threads_mask_busy} !==
          {m_held, e_pop, e_ben, e_num, e_tm}) begin
        n_fail++;
        $display("FAIL rand_hs cyc %0d: got v=%b pop=%b ben=%b num=%0d tm=%h required v=%b pop=%b ben=%b num=%0d tm=%h",
                 c, issue_valid, warp_pop, busy_en, warp_num_busy, threads_mask_busy,
                 m_held, e_pop, e_ben, e_num, e_tm);
      end
      if (m_held) begin
        n_cmp++;
        if ({issue_warp, issue_threads_mask, issue_is_mem} !== {m_warp, m_mask, m_mem}) begin
          n_fail++;
          $display("FAIL rand_payload cyc %0d: got w=%0d m=%h mem=%b required w=%0d m=%h mem=%b",
                   c, issue_warp, issue_threads_mask, issue_is_mem, m_warp, m_mask, m_mem);
        end
      end
      // Advance the model.
      if (m_held) begin
        if (fire) begin
          m_held      = 0;
          m_rr        = m_warp + 2'd1;
          m_pick_turn = 1;
        end
      end else if (m_pick_turn) begin
        found = 0;
        pw    = 0;
`ifdef WARP_AGE_EN
        for (int w = 0; w < 4; w++) begin
          if (!found && elig[w] && m_age[w] >= 12) begin
            found = 1;
            pw    = w;
          end
        end
`endif
        for (int i = 0; i < 4; i++) begin
          if (!found && elig[(int'(m_rr) + i) % 4]) begin
            found = 1;
            pw    = (int'(m_rr) + i) % 4;
          end
        end
        m_pick_turn = 0;
        if (found) begin
          m_held  = 1;
          m_warp  = 2'(pw);
          m_mask  = b_mask[pw];
          m_mem   = b_mem[pw];
          m_lanes = b_lanes[pw];
        end
      end else begin
        m_pick_turn = elig[0] || elig[1] || elig[2] || elig[3];
      end
      for (int w = 0; w < 4; w++) begin
        if (e_pop[w]) m_age[w] = 0;
        else if (b_v[w] && m_age[w] < 15) m_age[w] = m_age[w] + 1;
      end
      // Scoreboard: random clears, occasional foreign sets, and busy-set on memory accepts.
      for (int w = 0; w < 4; w++) begin
        b_busy[w] = b_busy[w] & (8'($urandom) | 8'($urandom));
        if ($urandom % 8 == 0) b_busy[w] = b_busy[w] | 8'(1 << ($urandom % 8));
      end
      if (e_ben) b_busy[e_num] = b_busy[e_num] | m_lanes;
      for (int w = 0; w < 4; w++) begin
        if (e_pop[w]) new_instr(w);
        else if (!b_v[w] && ($urandom % 3 == 0)) new_instr(w);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset       = 1'b0;
    issue_ready = 1'b0;
    setup_warps(4'h0, 4'h0);
    apply_inputs();
    test_reset();
    test_round_robin();
    test_mem_busy();
    test_stall();
    test_idle_wake();
`ifdef WARP_AGE_EN
    test_age();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running required completion by 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
